// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: accepts one load/store/ALU op, runs a single-beat memory access, and returns the result.
// Optional request timeout is built in when MEM_TIMEOUT_EN is defined.
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | ready for a new op (in_ready = 1)
// REQ   | mem_req asserted, waiting for mem_ack
// RESP  | out_valid asserted, waiting for out_ready
// EXC   | one-cycle exception pulse, op dropped
module mem_stage_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int WB_W        = 11,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_read,
    input  logic                in_write,
    input  logic [1:0]          in_len,
    input  logic                in_unsigned,
    input  logic [WB_W-1:0]     in_wb,
    input  logic [31:0]         in_addr,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [31:0]         in_pc,

    output logic                mem_req,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                out_valid,
    input  logic                out_ready,
    output logic [WB_W-1:0]     out_wb,
    output logic [DATA_W-1:0]   out_result,

    output logic                exc_valid,
    output logic                exc_adel,
    output logic                exc_ades,
    output logic                exc_timeout,
    output logic [31:0]         exc_epc,
    output logic [31:0]         exc_badaddr
);

    localparam int BE_W   = DATA_W / 8;
    localparam int LANE_W = $clog2(BE_W);

    typedef enum logic [1:0] {IDLE, REQ, RESP, EXC} state_t;

    state_t              state_q, state_d;
    logic [WB_W-1:0]     wb_q, wb_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [31:0]         epc_q, epc_d;
    logic [31:0]         badaddr_q, badaddr_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [1:0]          len_q, len_d;
    logic                uns_q, uns_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [BE_W-1:0]     we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                adel_q, adel_d;
    logic                ades_q, ades_d;

    logic [LANE_W-1:0]   in_lane;
    logic                in_is_mem;
    logic                in_misal;
    logic [2:0]          align_mask;
    logic [7:0]          be8;
    logic [BE_W-1:0]     in_be;
    logic [DATA_W-1:0]   in_wdata;
    logic [DATA_W-1:0]   rshift;
    logic [DATA_W-1:0]   load_val;

    assign in_lane   = in_addr[LANE_W-1:0];
    assign in_is_mem = in_read | in_write;

    always_comb begin
        align_mask = 3'b000;
        be8        = 8'h01;
        case (in_len)
            2'b00: begin align_mask = 3'b000; be8 = 8'h01; end
            2'b01: begin align_mask = 3'b001; be8 = 8'h03; end
            2'b10: begin align_mask = 3'b011; be8 = 8'h0F; end
            default: begin align_mask = 3'b111; be8 = 8'hFF; end
        endcase
    end

    // A dword on a 32-bit path can never be aligned.
    assign in_misal = (|(3'(in_lane) & align_mask)) | ((in_len == 2'b11) && (DATA_W == 32));
    assign in_be    = BE_W'(be8) << in_lane;
    assign in_wdata = in_data << {in_lane, 3'b000};

    assign rshift = mem_rdata >> {lane_q, 3'b000};

    always_comb begin
        load_val = rshift;
        case (len_q)
            2'b00:   load_val = uns_q ? DATA_W'(rshift[7:0])  : DATA_W'($signed(rshift[7:0]));
            2'b01:   load_val = uns_q ? DATA_W'(rshift[15:0]) : DATA_W'($signed(rshift[15:0]));
            2'b10:   load_val = uns_q ? DATA_W'(rshift[31:0]) : DATA_W'($signed(rshift[31:0]));
            default: load_val = rshift;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_q, tmo_d;
    logic        tmo_hit;
    assign tmo_hit = (tmo_cnt_q == 16'(TIMEOUT_CYC - 1));
`endif

    always_comb begin
        state_d   = state_q;
        wb_d      = wb_q;
        result_d  = result_q;
        epc_d     = epc_q;
        badaddr_d = badaddr_q;
        lane_d    = lane_q;
        len_d     = len_q;
        uns_d     = uns_q;
        write_d   = write_q;
        maddr_d   = maddr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        adel_d    = adel_q;
        ades_d    = ades_q;
`ifdef MEM_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        tmo_d     = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    wb_d      = in_wb;
                    epc_d     = in_pc;
                    badaddr_d = in_addr;
                    lane_d    = in_lane;
                    len_d     = in_len;
                    uns_d     = in_unsigned;
                    write_d   = in_write;
                    result_d  = in_data;
                    adel_d    = 1'b0;
                    ades_d    = 1'b0;
`ifdef MEM_TIMEOUT_EN
                    tmo_d     = 1'b0;
                    tmo_cnt_d = 16'd0;
`endif
                    if (in_is_mem && in_misal) begin
                        adel_d  = in_read & ~in_write;
                        ades_d  = in_write;
                        state_d = EXC;
                    end else if (in_is_mem) begin
                        maddr_d = in_addr[ADDR_W+LANE_W-1:LANE_W];
                        we_d    = in_write ? in_be : '0;
                        wdata_d = in_wdata;
                        state_d = REQ;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    if (!write_q) result_d = load_val;
                    state_d = RESP;
                end
`ifdef MEM_TIMEOUT_EN
                else if (tmo_hit) begin
                    tmo_d   = 1'b1;
                    state_d = EXC;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
`endif
            end
            RESP: begin
                if (out_ready) state_d = IDLE;
            end
            EXC: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            wb_q      <= '0;
            result_q  <= '0;
            epc_q     <= '0;
            badaddr_q <= '0;
            lane_q    <= '0;
            len_q     <= '0;
            uns_q     <= 1'b0;
            write_q   <= 1'b0;
            maddr_q   <= '0;
            we_q      <= '0;
            wdata_q   <= '0;
            adel_q    <= 1'b0;
            ades_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wb_q      <= wb_d;
            result_q  <= result_d;
            epc_q     <= epc_d;
            badaddr_q <= badaddr_d;
            lane_q    <= lane_d;
            len_q     <= len_d;
            uns_q     <= uns_d;
            write_q   <= write_d;
            maddr_q   <= maddr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            adel_q    <= adel_d;
            ades_q    <= ades_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt_q <= 16'd0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end
    assign exc_timeout = (state_q == EXC) & tmo_q;
`else
    assign exc_timeout = 1'b0;
`endif

    assign in_ready    = (state_q == IDLE);
    assign mem_req     = (state_q == REQ);
    assign mem_we      = mem_req ? we_q : '0;
    assign mem_addr    = maddr_q;
    assign mem_wdata   = wdata_q;
    assign out_valid   = (state_q == RESP);
    assign out_wb      = wb_q;
    assign out_result  = result_q;
    assign exc_valid   = (state_q == EXC);
    assign exc_adel    = (state_q == EXC) & adel_q;
    assign exc_ades    = (state_q == EXC) & ades_q;
    assign exc_epc     = epc_q;
    assign exc_badaddr = badaddr_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl (DATA_W=32, TIMEOUT_CYC=4).
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid, in_ready, in_read, in_write, in_unsigned;
    logic [1:0]  in_len;
    logic [10:0] in_wb;
    logic [31:0] in_addr, in_data, in_pc;
    logic        mem_req, mem_ack;
    logic [3:0]  mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        out_valid, out_ready;
    logic [10:0] out_wb;
    logic [31:0] out_result;
    logic        exc_valid, exc_adel, exc_ades, exc_timeout;
    logic [31:0] exc_epc, exc_badaddr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.DATA_W(32), .ADDR_W(8), .WB_W(11), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_read(in_read), .in_write(in_write),
        .in_len(in_len), .in_unsigned(in_unsigned), .in_wb(in_wb), .in_addr(in_addr),
        .in_data(in_data), .in_pc(in_pc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_wb(out_wb), .out_result(out_result),
        .exc_valid(exc_valid), .exc_adel(exc_adel), .exc_ades(exc_ades),
        .exc_timeout(exc_timeout), .exc_epc(exc_epc), .exc_badaddr(exc_badaddr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [1:0] len, input logic uns,
                         input logic [31:0] addr, input logic [31:0] data, input logic [31:0] pc,
                         input logic [10:0] wb);
        check("in_ready_pre", 64'(in_ready), 64'd1);
        in_valid    = 1'b1;
        in_read     = rd;
        in_write    = wr;
        in_len      = len;
        in_unsigned = uns;
        in_addr     = addr;
        in_data     = data;
        in_pc       = pc;
        in_wb       = wb;
        tick();
        in_valid = 1'b0;
        in_read  = 1'b0;
        in_write = 1'b0;
    endtask

    task automatic run_mem(input string tag, input logic rd, input logic wr, input logic [1:0] len,
                           input logic uns, input logic [31:0] addr, input logic [31:0] data,
                           input logic [10:0] wb, input logic [31:0] rdata, input int dly,
                           input logic [7:0] e_maddr, input logic [3:0] e_we,
                           input logic [31:0] e_wdata, input logic [31:0] e_res);
        issue(rd, wr, len, uns, addr, data, 32'h100, wb);
        check({tag, "_req"},   64'(mem_req),  64'd1);
        check({tag, "_maddr"}, 64'(mem_addr), 64'(e_maddr));
        check({tag, "_we"},    64'(mem_we),   64'(e_we));
        if (wr) check({tag, "_wdata"}, 64'(mem_wdata), 64'(e_wdata));
        check({tag, "_inrdy"}, 64'(in_ready), 64'd0);
        for (int i = 0; i < dly; i++) begin
            tick();
            check({tag, "_req_hold"},   64'(mem_req),  64'd1);
            check({tag, "_maddr_hold"}, 64'(mem_addr), 64'(e_maddr));
            check({tag, "_ov_early"},   64'(out_valid), 64'd0);
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_DEAD;
        check({tag, "_ov"},     64'(out_valid),  64'd1);
        check({tag, "_result"}, 64'(out_result), 64'(e_res));
        check({tag, "_wb"},     64'(out_wb),     64'(wb));
        check({tag, "_reqoff"}, 64'(mem_req),    64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ov_done"}, 64'(out_valid), 64'd0);
        check({tag, "_idle"},    64'(in_ready),  64'd1);
    endtask

    task automatic run_exc(input string tag, input logic rd, input logic wr, input logic [1:0] len,
                           input logic [31:0] addr, input logic [31:0] pc,
                           input logic e_adel, input logic e_ades);
        issue(rd, wr, len, 1'b0, addr, 32'h1234_5678, pc, 11'h7);
        check({tag, "_exc"},     64'(exc_valid),   64'd1);
        check({tag, "_adel"},    64'(exc_adel),    64'(e_adel));
        check({tag, "_ades"},    64'(exc_ades),    64'(e_ades));
        check({tag, "_epc"},     64'(exc_epc),     64'(pc));
        check({tag, "_badaddr"}, 64'(exc_badaddr), 64'(addr));
        check({tag, "_noreq"},   64'(mem_req),     64'd0);
        check({tag, "_noov"},    64'(out_valid),   64'd0);
        tick();
        check({tag, "_pulse"},   64'(exc_valid),   64'd0);
        check({tag, "_idle"},    64'(in_ready),    64'd1);
        check({tag, "_noov2"},   64'(out_valid),   64'd0);
    endtask

    initial begin
        resetn = 1'b0;
        in_valid = 1'b0; in_read = 1'b0; in_write = 1'b0; in_len = 2'b00; in_unsigned = 1'b0;
        in_wb = '0; in_addr = '0; in_data = '0; in_pc = '0;
        mem_ack = 1'b0; mem_rdata = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready),   64'd1);
        check("rst_mem_req",  64'(mem_req),    64'd0);
        check("rst_mem_we",   64'(mem_we),     64'd0);
        check("rst_ov",       64'(out_valid),  64'd0);
        check("rst_exc",      64'(exc_valid),  64'd0);
        check("rst_result",   64'(out_result), 64'd0);
        check("rst_maddr",    64'(mem_addr),   64'd0);
        check("rst_epc",      64'(exc_epc),    64'd0);
        resetn = 1'b1;
        tick();
        check("rst_rel_ready", 64'(in_ready), 64'd1);

        // Stray ack while idle must not start anything.
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("stray_req", 64'(mem_req),   64'd0);
        check("stray_ov",  64'(out_valid), 64'd0);

        //       tag     rd    wr    len    uns   addr       data           wb      rdata          dly maddr  we       wdata          result
        run_mem("lw",   1'b1, 1'b0, 2'b10, 1'b0, 32'h10,    32'h0,         11'h11, 32'h8899AABB, 3, 8'h04, 4'b0000, 32'h0,         32'h8899AABB);
        run_mem("lb",   1'b1, 1'b0, 2'b00, 1'b0, 32'h13,    32'h0,         11'h12, 32'h80112233, 0, 8'h04, 4'b0000, 32'h0,         32'hFFFFFF80);
        run_mem("lbu",  1'b1, 1'b0, 2'b00, 1'b1, 32'h13,    32'h0,         11'h13, 32'h80112233, 0, 8'h04, 4'b0000, 32'h0,         32'h00000080);
        run_mem("sh",   1'b0, 1'b1, 2'b01, 1'b0, 32'h22,    32'h0000BEEF,  11'h14, 32'h0,        1, 8'h08, 4'b1100, 32'hBEEF0000,  32'h0000BEEF);
        run_mem("lh",   1'b1, 1'b0, 2'b01, 1'b0, 32'h02,    32'h0,         11'h15, 32'h80011234, 2, 8'h00, 4'b0000, 32'h0,         32'hFFFF8001);
        run_mem("lhu",  1'b1, 1'b0, 2'b01, 1'b1, 32'h06,    32'h0,         11'h16, 32'hF00D1234, 0, 8'h01, 4'b0000, 32'h0,         32'h0000F00D);
        run_mem("sb",   1'b0, 1'b1, 2'b00, 1'b0, 32'h3FD,   32'h12345678,  11'h17, 32'h0,        1, 8'hFF, 4'b0010, 32'h34567800,  32'h12345678);
        run_mem("rdwr", 1'b1, 1'b1, 2'b10, 1'b0, 32'h10,    32'hCAFEF00D,  11'h18, 32'h11111111, 0, 8'h04, 4'b1111, 32'hCAFEF00D,  32'hCAFEF00D);

        run_exc("lw_mis", 1'b1, 1'b0, 2'b10, 32'h102, 32'h400, 1'b1, 1'b0);
        run_exc("sd32",   1'b0, 1'b1, 2'b11, 32'h20,  32'h404, 1'b0, 1'b1);
        run_exc("sh_mis", 1'b0, 1'b1, 2'b01, 32'h21,  32'h408, 1'b0, 1'b1);

        // Non-memory op with an odd address is not an exception; hold out_ready low.
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h3, 32'h5, 32'h500, 11'h2A);
        check("alu_ov",     64'(out_valid),  64'd1);
        check("alu_result", 64'(out_result), 64'd5);
        check("alu_noreq",  64'(mem_req),    64'd0);
        check("alu_noexc",  64'(exc_valid),  64'd0);
        in_valid = 1'b1;
        in_data  = 32'h77;
        in_wb    = 11'h55;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("alu_hold_ov",  64'(out_valid),  64'd1);
            check("alu_hold_res", 64'(out_result), 64'd5);
            check("alu_hold_wb",  64'(out_wb),     64'h2A);
            check("alu_hold_rdy", 64'(in_ready),   64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("alu_done_ov",  64'(out_valid), 64'd0);
        check("alu_done_rdy", 64'(in_ready),  64'd1);

        // Reset in the middle of a request.
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h600, 11'h3);
        check("rstreq_req", 64'(mem_req), 64'd1);
        tick();
        tick();
        resetn = 1'b0;
        #1;
        check("rstreq_req_off", 64'(mem_req),    64'd0);
        check("rstreq_ready",   64'(in_ready),   64'd1);
        check("rstreq_maddr",   64'(mem_addr),   64'd0);
        tick();
        resetn = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h99999999;
        tick();
        mem_ack = 1'b0;
        check("rstreq_stray_ov",  64'(out_valid),  64'd0);
        check("rstreq_stray_res", 64'(out_result), 64'd0);
        check("rstreq_ready2",    64'(in_ready),   64'd1);

`ifdef MEM_TIMEOUT_EN
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 32'h700, 11'h4);
        for (int i = 0; i < 4; i++) begin
            check("tmo_req_on", 64'(mem_req), 64'd1);
            tick();
        end
        check("tmo_req_off", 64'(mem_req),     64'd0);
        check("tmo_exc",     64'(exc_valid),   64'd1);
        check("tmo_flag",    64'(exc_timeout), 64'd1);
        check("tmo_adel",    64'(exc_adel),    64'd0);
        check("tmo_epc",     64'(exc_epc),     64'h700);
        check("tmo_badaddr", 64'(exc_badaddr), 64'h44);
        tick();
        check("tmo_pulse", 64'(exc_valid), 64'd0);
        check("tmo_noov",  64'(out_valid), 64'd0);
        check("tmo_idle",  64'(in_ready),  64'd1);
`else
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 32'h700, 11'h4);
        for (int i = 0; i < 8; i++) begin
            check("notmo_req",  64'(mem_req),     64'd1);
            check("notmo_flag", 64'(exc_timeout), 64'd0);
            check("notmo_exc",  64'(exc_valid),   64'd0);
            tick();
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BADF00D;
        tick();
        mem_ack = 1'b0;
        check("notmo_ov",  64'(out_valid),  64'd1);
        check("notmo_res", 64'(out_result), 64'h0BADF00D);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("notmo_idle", 64'(in_ready), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
